// File: rtl/width_downsizer.sv
`default_nettype none
// ============================================================================
// Module      : width_downsizer
// Description : Valid/ready serializer splitting IN_W-bit words into
//               IN_W/OUT_W beats of OUT_W bits. The optional build macro
//               WIDTH_DOWNSIZER_MSB_FIRST_EN emits the most-significant
//               slice first. The default is least-significant first.
// Revision    : 1.0 - initial release
// ============================================================================
module width_downsizer #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);
    localparam int RATIO  = IN_W / OUT_W;
    localparam int BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);

    generate
        if (((IN_W % OUT_W) != 0) || (RATIO < 2)) begin : g_param_check
            $error("width_downsizer: IN_W must be a multiple of OUT_W with IN_W/OUT_W >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   hold_q, hold_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              w_busy;
    logic              w_out_fire;
    logic              w_in_fire;
    logic [BEAT_W-1:0] w_slice_idx;

    assign w_busy     = (state_q == SEND);
    assign out_valid  = w_busy;
    assign out_last   = w_busy && (beat_q == LAST_BEAT);
    assign w_out_fire = out_valid && out_ready;
    // A new word may be taken in the same cycle the last beat leaves.
    assign in_ready   = !w_busy || (w_out_fire && out_last);
    assign w_in_fire  = in_valid && in_ready;

`ifdef WIDTH_DOWNSIZER_MSB_FIRST_EN
    assign w_slice_idx = LAST_BEAT - beat_q;
`else
    assign w_slice_idx = beat_q;
`endif

    assign out_data = hold_q[w_slice_idx*OUT_W +: OUT_W];

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (w_in_fire) begin
                    hold_d  = in_data;
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (w_out_fire) begin
                    if (out_last) begin
                        beat_d = '0;
                        if (w_in_fire) begin
                            hold_d = in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            beat_q  <= beat_d;
        end
    end

endmodule
`default_nettype wire
